fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core; it sits directly upstream of the decoder and drives its 32-bit `ir` input. It owns the PC and issues in-order word fetches to instruction memory over a valid/ready request channel. It buffers returned instructions, each paired with its PC, in a small in-order queue and presents the queue head to the ID stage. Redirects from later stages flush the queue and discard responses still in flight.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Life cycle of one queue slot.
  typedef enum logic [1:0] {
    E_FREE    = 2'd0,
    E_PENDING = 2'd1,
    E_READY   = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e        state;
    logic [31:0]         pc;
    logic [INSTR_W-1:0]  ir;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction queue: slots are allocated at the tail on request,
// filled in order on response, and popped from the head.
//
// entry state | meaning
// ------------+---------------------------------------------
// E_FREE      | slot unused
// E_PENDING   | request issued, instruction not yet returned
// E_READY     | instruction returned, waiting for ID
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               alloc,
  input  logic [31:0]        alloc_pc,
  input  logic               fill,
  input  logic [INSTR_W-1:0] fill_ir,
  input  logic               pop,
  output logic [CW-1:0]      occ,
  output logic [CW-1:0]      pend_cnt,
  output logic               head_ready,
  output logic [31:0]        head_pc,
  output logic [INSTR_W-1:0] head_ir
);

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [AW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [AW-1:0] head_ptr_q, head_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] pend_q, pend_d;
  logic          do_fill;
  logic          do_pop;

  // Pending slots are contiguous from fill_ptr, so a fill with none is ignored.
  assign do_fill    = fill && (pend_q != '0);
  assign head_ready = (ent_q[head_ptr_q].state == E_READY);
  assign do_pop     = pop && head_ready;
  assign head_pc    = head_ready ? ent_q[head_ptr_q].pc : '0;
  assign head_ir    = head_ready ? ent_q[head_ptr_q].ir : '0;
  assign occ        = occ_q;
  assign pend_cnt   = pend_q;

  // Next queue contents: flush wins, otherwise alloc/fill/pop may all coincide.
  always_comb begin
    ent_d       = ent_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    occ_d       = occ_q;
    pend_d      = pend_q;
    if (flush) begin
      foreach (ent_d[i]) ent_d[i].state = E_FREE;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      occ_d       = '0;
      pend_d      = '0;
    end else begin
      if (alloc) begin
        ent_d[alloc_ptr_q] = '{state: E_PENDING, pc: alloc_pc, ir: '0};
        alloc_ptr_d        = alloc_ptr_q + AW'(1);
      end
      if (do_fill) begin
        ent_d[fill_ptr_q].state = E_READY;
        ent_d[fill_ptr_q].ir    = fill_ir;
        fill_ptr_d              = fill_ptr_q + AW'(1);
      end
      if (do_pop) begin
        ent_d[head_ptr_q].state = E_FREE;
        head_ptr_d              = head_ptr_q + AW'(1);
      end
      occ_d  = occ_q + CW'(alloc) - CW'(do_pop);
      pend_d = pend_q + CW'(alloc) - CW'(do_fill);
    end
  end

  // Queue registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      foreach (ent_q[i]) ent_q[i] <= '{state: E_FREE, pc: '0, ir: '0};
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
    end else begin
      ent_q       <= ent_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches, tracks responses
// to discard after a redirect, and presents the queue head to ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_ir,
  output logic [31:0]        if_pc
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] occ;
  logic [CW-1:0] pend_cnt;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          q_fill;
  logic          q_pop;
  logic          unused_redirect_lsb;

  // Responses still owed to discarded slots consume request credit too,
  // so the memory never holds more than DEPTH outstanding fetches.
  assign credit_used    = {1'b0, occ} + {1'b0, drop_cnt_q};
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign q_fill         = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign q_pop          = if_valid && !id_stall && !redirect_valid;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc      (req_fire),
    .alloc_pc   (pc_q),
    .fill       (q_fill),
    .fill_ir    (imem_resp_data),
    .pop        (q_pop),
    .occ        (occ),
    .pend_cnt   (pend_cnt),
    .head_ready (if_valid),
    .head_pc    (if_pc),
    .head_ir    (if_ir)
  );

  // Next PC and drop count; a redirect turns every pending slot into a drop,
  // and a response landing in the redirect cycle is itself discarded.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      drop_cnt_d = drop_cnt_q + pend_cnt - CW'(imem_resp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // PC and drop counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle,
// in-order memory model with configurable latency, directed and random phases.
module tb_fetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_stall        (id_stall),
    .if_valid        (if_valid),
    .if_ir           (if_ir),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] ir; } inst_t;
  typedef struct { logic [31:0] addr; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; int cyc; } id_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  known    = 0;

  // reference model: what has been asked for, what is waiting for ID
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  inst_t       m_rdy[$];
  int          m_drop;

  req_t req_log[$];
  id_t  id_log[$];

  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          mem_k      = 1;
  bit          mem_k_rand = 0;

  bit          prev_hold = 0;
  logic [31:0] prev_addr = '0;
  int          rel_cyc   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit have(string name, int got, int need);
    n_checks++;
    if (got < need) begin
      n_fail++;
      $display("FAIL %s: got %0d entries expected at least %0d", name, got, need);
      return 0;
    end
    return 1;
  endfunction

  // compare outputs against the model, log events, then advance the model
  always @(negedge clk) begin
    bit          exp_rv;
    bit          do_pop;
    int          outstanding;
    logic [31:0] p;
    outstanding = m_pend.size() + m_rdy.size() + m_drop;
    exp_rv = rst_n && !redirect_valid && (outstanding < DEPTH);
    if (known) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", 32'(if_valid), 32'(m_rdy.size() > 0));
      chk("if_pc", if_pc, (m_rdy.size() > 0) ? m_rdy[0].pc : 32'h0);
      chk("if_ir", if_ir, (m_rdy.size() > 0) ? m_rdy[0].ir : 32'h0);
      chk("drop_cnt", 32'(dut.drop_cnt_q), 32'(m_drop));
    end
    if (prev_hold && rst_n && !redirect_valid) begin
      chk("hold_valid", 32'(imem_req_valid), 32'd1);
      chk("hold_addr", imem_req_addr, prev_addr);
    end
    prev_hold = rst_n && imem_req_valid && !imem_req_ready;
    prev_addr = imem_req_addr;

    if (rst_n && !redirect_valid && imem_resp_valid)
      assert (m_drop > 0 || m_pend.size() > 0)
      else begin
        n_fail++;
        $display("FAIL protocol: response with nothing pending (cycle %0d)", cyc);
      end

    if (rst_n && imem_req_valid && imem_req_ready) req_log.push_back('{imem_req_addr, cyc});
    if (rst_n && !redirect_valid && if_valid && !id_stall) id_log.push_back('{if_pc, if_ir, cyc});

    if (!rst_n) begin
      m_pc   = 32'h0;
      m_drop = 0;
      m_pend.delete();
      m_rdy.delete();
      known  = 1;
    end else if (redirect_valid) begin
      m_drop = m_drop + m_pend.size() - (imem_resp_valid ? 1 : 0);
      m_pend.delete();
      m_rdy.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      do_pop = (m_rdy.size() > 0) && !id_stall;
      if (imem_resp_valid) begin
        if (m_drop > 0) m_drop--;
        else if (m_pend.size() > 0) begin
          p = m_pend.pop_front();
          m_rdy.push_back('{p, p ^ KEY});
        end
      end
      if (do_pop) void'(m_rdy.pop_front());
      if (exp_rv && imem_req_ready) begin
        m_pend.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // memory: capture accepted requests, schedule in-order responses
  always @(negedge clk) begin
    int k;
    int due;
    if (!rst_n) begin
      mem_addr.delete();
      mem_due.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      k   = mem_k_rand ? int'($urandom_range(1, 3)) : mem_k;
      due = cyc + k;
      if (mem_due.size() > 0 && due <= mem_due[mem_due.size()-1]) due = mem_due[mem_due.size()-1] + 1;
      mem_addr.push_back(imem_req_addr);
      mem_due.push_back(due);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_due.size() > 0 && mem_due[0] == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_addr.pop_front() ^ KEY;
      void'(mem_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic reset_seq();
    tick();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    run(2);
    req_log.delete();
    id_log.delete();
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic redirect(logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    req_log.delete();
    id_log.delete();
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int w;
    int r_cyc;
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;

    // straight-line fetch
    reset_seq();
    run(12);
    if (have("t1_reqs", req_log.size(), 6) && have("t1_ids", id_log.size(), 6)) begin
      chk("t1_first_req_cyc", 32'(req_log[0].cyc), 32'(rel_cyc));
      chk("t1_latency", 32'(id_log[0].cyc - req_log[0].cyc), 32'd2);
      chk("t1_first_pc", id_log[0].pc, 32'h0);
      chk("t1_first_ir", id_log[0].ir, 32'hA5A5_0000);
      for (int i = 0; i < 6; i++) begin
        chk("t1_req_addr", req_log[i].addr, 32'(4 * i));
        chk("t1_req_cyc", 32'(req_log[i].cyc), 32'(rel_cyc + i));
        chk("t1_id_pc", id_log[i].pc, 32'(4 * i));
        chk("t1_id_cyc", 32'(id_log[i].cyc), 32'(id_log[0].cyc + i));
      end
    end

    // full queue under stall
    id_stall = 1'b1;
    reset_seq();
    run(10);
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_idle", 32'(imem_req_valid), 32'd0);
    if (have("t2_reqs", req_log.size(), 4))
      for (int i = 0; i < 4; i++) chk("t2_req_addr", req_log[i].addr, 32'(4 * i));
    req_log.delete();
    id_log.delete();
    id_stall = 1'b0;
    run(10);
    if (have("t2_pops", id_log.size(), 4) && have("t2_resume", req_log.size(), 1)) begin
      for (int i = 0; i < 4; i++) chk("t2_pop_pc", id_log[i].pc, 32'(4 * i));
      chk("t2_resume_addr", req_log[0].addr, 32'h10);
    end

    // redirect with three responses in flight (first lands in the redirect cycle)
    mem_k = 3;
    reset_seq();
    w = 0;
    while (req_log.size() < 3 && w < 20) begin tick(); w++; end
    if (have("t3_wait", req_log.size(), 3)) begin
      r_cyc = cyc;
      redirect(32'h0000_0103);
      chk("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
      run(12);
      if (have("t3_reqs", req_log.size(), 1) && have("t3_ids", id_log.size(), 1)) begin
        chk("t3_req_addr", req_log[0].addr, 32'h100);
        chk("t3_req_cyc", 32'(req_log[0].cyc), 32'(r_cyc + 1));
        chk("t3_id_pc", id_log[0].pc, 32'h100);
        chk("t3_id_ir", id_log[0].ir, 32'h100 ^ KEY);
        chk("t3_id_late", 32'(id_log[0].cyc >= r_cyc + 3), 32'd1);
      end
    end

    // redirect during a response stream, to the top of memory
    mem_k = 1;
    reset_seq();
    run(5);
    redirect(32'hFFFF_FFFC);
    run(6);
    if (have("t4_reqs", req_log.size(), 2) && have("t4_ids", id_log.size(), 2)) begin
      chk("t4_req0", req_log[0].addr, 32'hFFFF_FFFC);
      chk("t4_req1", req_log[1].addr, 32'h0000_0000);
      chk("t4_id0", id_log[0].pc, 32'hFFFF_FFFC);
      chk("t4_id1", id_log[1].pc, 32'h0000_0000);
    end

    // random back-pressure and stalls, no redirect
    mem_k_rand = 1'b1;
    reset_seq();
    repeat (400) begin
      tick();
      imem_req_ready = 1'($urandom_range(0, 1));
      id_stall       = ($urandom_range(0, 3) == 0);
    end
    imem_req_ready = 1'b1;
    id_stall = 1'b0;
    run(10);
    if (have("t5_ids", id_log.size(), 20))
      for (int i = 1; i < id_log.size(); i++) chk("t5_seq_pc", id_log[i].pc, id_log[i-1].pc + 32'd4);

    // random everything including redirects
    repeat (600) begin
      tick();
      imem_req_ready = 1'($urandom_range(0, 1));
      id_stall       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
    end
    redirect_valid = 1'b0;

    // reset with a full queue
    mem_k_rand = 1'b0;
    imem_req_ready = 1'b1;
    id_stall = 1'b1;
    reset_seq();
    run(2);
    redirect(32'h0000_0040);
    run(10);
    chk("t6_full_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_if_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_if_pc", if_pc, 32'h0);
    chk("t6_rst_if_ir", if_ir, 32'h0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    id_stall = 1'b0;
    req_log.delete();
    id_log.delete();
    rst_n = 1'b1;
    rel_cyc = cyc;
    run(4);
    if (have("t6_reqs", req_log.size(), 1)) begin
      chk("t6_req_addr", req_log[0].addr, 32'h0);
      chk("t6_req_cyc", 32'(req_log[0].cyc), 32'(rel_cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
